// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rsn_seq_pkg.sv
// Shared types and helpers for the RN/SETN preset-clear sequencer.
// Holds the FSM state encoding, the pulse/guard counter width helper and
// the lower bounds that the top clamps its parameters against.
package gf180mcu_fd_sc_mcu9t5v0__rsn_seq_pkg;

  localparam int MIN_SYNC_STAGES  = 2;
  localparam int MIN_PULSE_CYCLES = 1;
  localparam int MIN_GUARD_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_RST_SYNC  = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CLR_PULSE = 3'd2,
    ST_SET_PULSE = 3'd3,
    ST_GUARD     = 3'd4
  } state_e;

  // Width needed to hold the larger of the pulse and guard reload values.
  function automatic int cnt_width(input int pulse, input int guard);
    int m;
    m = (pulse > guard) ? pulse : guard;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Raise an out-of-range parameter to its legal minimum.
  function automatic int clamp_min(input int value, input int lo);
    return (value < lo) ? lo : value;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rsn_sync.sv
// Reset-release synchronizer: asserts asynchronously, releases synchronously.
// The consuming FSM state register acts as the final stage of the chain, so
// the sequencer instantiates this with one flop fewer than its total depth.
module gf180mcu_fd_sc_mcu9t5v0__rsn_sync #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_o
);

  logic [DEPTH-1:0] sync_q;

  // Shift a constant one through the chain once reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rsn_seq.sv
// Preset/clear sequencer for a bank of dffrsnq flops.
// Drives RN_O/SETN_O as mutually exclusive timed low pulses followed by a
// guard gap. Optional feature macro GF180MCU_RSN_SEQ_PENDING_EN adds one
// pending slot each for clear and set; without it every request that cannot
// be served immediately is discarded with a DROP pulse.
//
// Handshake: CLR_REQ/SET_REQ are single-cycle strobes with no ready; a
// request is accepted directly only at an edge where BUSY was low, otherwise
// it is stored (if a free slot exists) or discarded with DROP high for the
// following cycle. A slot full before the edge counts as full even if it is
// consumed on that same edge.
module gf180mcu_fd_sc_mcu9t5v0__rsn_seq
  import gf180mcu_fd_sc_mcu9t5v0__rsn_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int GUARD_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       CLR_REQ,
  input  logic       SET_REQ,
  output logic       RN_O,
  output logic       SETN_O,
  output logic       BUSY,
  output logic       DROP,
  output logic [2:0] STATE_O
);

  localparam int SYNC_N  = clamp_min(SYNC_STAGES, MIN_SYNC_STAGES);
  localparam int PULSE_N = clamp_min(PULSE_CYCLES, MIN_PULSE_CYCLES);
  localparam int GUARD_N = clamp_min(GUARD_CYCLES, MIN_GUARD_CYCLES);
  localparam int CW      = cnt_width(PULSE_N, GUARD_N);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_N - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_N - 1);

`ifdef GF180MCU_RSN_SEQ_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_clr_q, pend_clr_d;
  logic          pend_set_q, pend_set_d;
  logic          rn_o_q, setn_o_q, busy_q, drop_q;
  logic          sync_ok;
  logic          clr_direct, set_direct, clr_take, set_take;
  logic          clr_busy, set_busy, clr_store, set_store, drop_d;

  gf180mcu_fd_sc_mcu9t5v0__rsn_sync #(
    .DEPTH (SYNC_N - 1)
  ) u_sync (
    .clk_i  (CLK),
    .rst_ni (RN),
    .sync_o (sync_ok)
  );

  // Next-state, counter reload and pending-slot bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_direct = 1'b0;
    set_direct = 1'b0;
    clr_take   = 1'b0;
    set_take   = 1'b0;
    case (state_q)
      ST_RST_SYNC: begin
        if (sync_ok) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Stored requests (only possible from RST_SYNC) are served first.
        if (CLR_REQ || pend_clr_q) begin
          state_d    = ST_CLR_PULSE;
          cnt_d      = PULSE_LD;
          clr_take   = pend_clr_q;
          clr_direct = CLR_REQ && !pend_clr_q;
        end else if (SET_REQ || pend_set_q) begin
          state_d    = ST_SET_PULSE;
          cnt_d      = PULSE_LD;
          set_take   = pend_set_q;
          set_direct = SET_REQ && !pend_set_q;
        end
      end
      ST_CLR_PULSE, ST_SET_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          if (pend_clr_q) begin
            state_d  = ST_CLR_PULSE;
            cnt_d    = PULSE_LD;
            clr_take = 1'b1;
          end else if (pend_set_q) begin
            state_d  = ST_SET_PULSE;
            cnt_d    = PULSE_LD;
            set_take = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_RST_SYNC;
    endcase

    clr_busy   = CLR_REQ && !clr_direct;
    set_busy   = SET_REQ && !set_direct;
    clr_store  = PEND_EN && clr_busy && !pend_clr_q;
    set_store  = PEND_EN && set_busy && !pend_set_q;
    pend_clr_d = (pend_clr_q && !clr_take) || clr_store;
    pend_set_d = (pend_set_q && !set_take) || set_store;
    drop_d     = (clr_busy && !clr_store) || (set_busy && !set_store);
  end

  // FSM registers with outputs registered from the next state.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_RST_SYNC;
      cnt_q      <= '0;
      pend_clr_q <= 1'b0;
      pend_set_q <= 1'b0;
      rn_o_q     <= 1'b0;
      setn_o_q   <= 1'b1;
      busy_q     <= 1'b1;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_clr_q <= pend_clr_d;
      pend_set_q <= pend_set_d;
      rn_o_q     <= (state_d != ST_RST_SYNC) && (state_d != ST_CLR_PULSE);
      setn_o_q   <= (state_d != ST_SET_PULSE);
      busy_q     <= (state_d != ST_IDLE);
      drop_q     <= drop_d;
    end
  end

  assign RN_O    = rn_o_q;
  assign SETN_O  = setn_o_q;
  assign BUSY    = busy_q;
  assign DROP    = drop_q;
  assign STATE_O = state_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rsn_seq.sv
// Self-checking bench for the RN/SETN preset-clear sequencer.
// Reference model tracks each sequence as a start time plus fixed pulse and
// guard lengths, with pending requests held as flags.
module tb_gf180mcu_fd_sc_mcu9t5v0__rsn_seq;

  localparam int SYNC = 2;
  localparam int P    = 2;
  localparam int G    = 1;
`ifdef GF180MCU_RSN_SEQ_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic       CLK;
  logic       RN;
  logic       CLR_REQ;
  logic       SET_REQ;
  logic       RN_O;
  logic       SETN_O;
  logic       BUSY;
  logic       DROP;
  logic [2:0] STATE_O;

  int n_checks;
  int n_errors;

  // Scoreboard: expected {RN_O, SETN_O, BUSY, DROP} per observation.
  logic [3:0] exp_q[$];

  // Reference model state.
  int m_t;
  bit m_syncing;
  int m_sync_left;
  int m_seq;    // 0 none, 1 clear sequence, 2 set sequence
  int m_start;
  bit m_pc;
  bit m_ps;

  gf180mcu_fd_sc_mcu9t5v0__rsn_seq #(
    .SYNC_STAGES  (SYNC),
    .PULSE_CYCLES (P),
    .GUARD_CYCLES (G)
  ) dut (
    .CLK     (CLK),
    .RN      (RN),
    .CLR_REQ (CLR_REQ),
    .SET_REQ (SET_REQ),
    .RN_O    (RN_O),
    .SETN_O  (SETN_O),
    .BUSY    (BUSY),
    .DROP    (DROP),
    .STATE_O (STATE_O)
  );

  // Clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 4'd1, 4'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("rn_o",   4'(RN_O),   4'(e[3]));
    check_eq("setn_o", 4'(SETN_O), 4'(e[2]));
    check_eq("busy",   4'(BUSY),   4'(e[1]));
    check_eq("drop",   4'(DROP),   4'(e[0]));
    check_eq("excl",   4'(RN_O | SETN_O), 4'd1);
  endtask

  // Model: reset held low.
  task automatic model_reset();
    m_syncing   = 1'b1;
    m_sync_left = SYNC;
    m_seq       = 0;
    m_pc        = 1'b0;
    m_ps        = 1'b0;
    exp_q.push_back(4'b0110);
  endtask

  // Model: one rising edge with RN high and the given request strobes.
  task automatic model_edge(input bit c, input bit s);
    bit bc, bs, tc, ts, sc, ss, dr, rn, setn, busy;
    int age;
    bc = c; bs = s; tc = 1'b0; ts = 1'b0;
    if (m_syncing) begin
      m_sync_left--;
      if (m_sync_left == 0) m_syncing = 1'b0;
    end else if (m_seq == 0) begin
      if (c || m_pc) begin
        m_seq = 1; m_start = m_t;
        if (m_pc) tc = 1'b1; else bc = 1'b0;
      end else if (s || m_ps) begin
        m_seq = 2; m_start = m_t;
        if (m_ps) ts = 1'b1; else bs = 1'b0;
      end
    end else if (m_t - m_start == P + G) begin
      if (m_pc) begin
        m_seq = 1; m_start = m_t; tc = 1'b1;
      end else if (m_ps) begin
        m_seq = 2; m_start = m_t; ts = 1'b1;
      end else begin
        m_seq = 0;
      end
    end
    sc   = PEND && bc && !m_pc;
    ss   = PEND && bs && !m_ps;
    dr   = (bc && !sc) || (bs && !ss);
    m_pc = (m_pc && !tc) || sc;
    m_ps = (m_ps && !ts) || ss;
    age  = m_t - m_start;
    rn   = !(m_syncing || (m_seq == 1 && age < P));
    setn = !(m_seq == 2 && age < P);
    busy = m_syncing || (m_seq != 0);
    exp_q.push_back({rn, setn, busy, dr});
    m_t++;
  endtask

  // Driver: present strobes for one edge, then check just after it.
  task automatic do_cycle(input bit c, input bit s);
    CLR_REQ = c;
    SET_REQ = s;
    @(posedge CLK);
    model_edge(c, s);
    #1;
    compare_outputs();
    CLR_REQ = 1'b0;
    SET_REQ = 1'b0;
  endtask

  // Driver: assert RN mid-cycle, hold for n edges, release mid-cycle.
  task automatic do_reset(input int n);
    #2;
    RN = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      exp_q.push_back(4'b0110);
      #1;
      compare_outputs();
    end
    RN = 1'b1;
    m_sync_left = SYNC;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_t      = 0;
    m_start  = 0;
    RN       = 1'b1;
    CLR_REQ  = 1'b0;
    SET_REQ  = 1'b0;

    // Power-on reset for three cycles, then synchronized release.
    do_reset(3);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0);

    // Single clear from idle.
    do_cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0);

    // Single set from idle.
    do_cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0);

    // Simultaneous clear and set.
    do_cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0);

    // Three sets while busy with a clear.
    do_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0);

    // Reset hit during a set pulse, with a clear pending.
    do_cycle(1'b0, 1'b1);
    do_cycle(1'b1, 1'b0);
    do_reset(2);
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b0);

    // Requests during reset release are not served directly.
    do_reset(1);
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        do_cycle($urandom_range(0, 99) < 18, $urandom_range(0, 99) < 18);
      end
    end
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
